// File: rtl/fi_sabouter_ctrl_if.sv
// Bundle between the fault-injection campaign side and the saboteur controller.
// Handshake: a descriptor transfers on any rising edge where i_cfg_valid && o_cfg_ready are both high;
// the fields only need to be stable at that edge, and valid is simply ignored while ready is low.
interface fi_sabouter_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
);
    logic             i_cfg_valid;
    logic             o_cfg_ready;
    logic [WIDTH-1:0] i_cfg_mask;
    logic [1:0]       i_cfg_ctrl;
    logic [CNT_W-1:0] i_cfg_start;
    logic [CNT_W-1:0] i_cfg_dur;
    logic             i_trigger;
    logic             i_abort;
    logic             o_en_super_sabouter;
    logic [WIDTH-1:0] o_en_basic_sabouter;
    logic [1:0]       o_ctrl;
    logic             o_busy;
    logic             o_done;
    logic [CNT_W-1:0] o_inj_cnt;
    logic [2:0]       dbg_state;

    modport master (
        output i_cfg_valid, i_cfg_mask, i_cfg_ctrl, i_cfg_start, i_cfg_dur,
        output i_trigger, i_abort,
        input  o_cfg_ready, o_en_super_sabouter, o_en_basic_sabouter, o_ctrl,
        input  o_busy, o_done, o_inj_cnt, dbg_state
    );

    modport slave (
        input  i_cfg_valid, i_cfg_mask, i_cfg_ctrl, i_cfg_start, i_cfg_dur,
        input  i_trigger, i_abort,
        output o_cfg_ready, o_en_super_sabouter, o_en_basic_sabouter, o_ctrl,
        output o_busy, o_done, o_inj_cnt, dbg_state
    );
endinterface

// File: rtl/fi_sabouter_ctrl.sv
// Saboteur bank controller: accepts one injection descriptor, waits for the workload trigger,
// delays, then holds the saboteur enables for the programmed window and counts completions.
module fi_sabouter_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    fi_sabouter_ctrl_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        DELAY  = 3'd2,
        INJECT = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mask_q;
    logic [1:0]       ctrl_q;
    logic [CNT_W-1:0] start_q;
    logic [CNT_W-1:0] dur_q;
    logic [CNT_W-1:0] cnt;
    logic             cfg_ready;
    logic             en_super;
    logic [WIDTH-1:0] en_basic;
    logic [1:0]       ctrl_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] inj_cnt;

    // cnt is shared: it holds (remaining - 1) for the delay phase, then for the injection window.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            mask_q    <= '0;
            ctrl_q    <= '0;
            start_q   <= '0;
            dur_q     <= '0;
            cnt       <= '0;
            cfg_ready <= 1'b1;
            en_super  <= 1'b0;
            en_basic  <= '0;
            ctrl_out  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            inj_cnt   <= '0;
        end else begin
            done <= 1'b0;
            if (bus.i_abort) begin
                state     <= IDLE;
                cfg_ready <= 1'b1;
                busy      <= 1'b0;
                en_super  <= 1'b0;
                en_basic  <= '0;
                ctrl_out  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.i_cfg_valid) begin
                            mask_q    <= bus.i_cfg_mask;
                            ctrl_q    <= bus.i_cfg_ctrl;
                            start_q   <= bus.i_cfg_start;
                            dur_q     <= bus.i_cfg_dur;
                            state     <= ARMED;
                            cfg_ready <= 1'b0;
                            busy      <= 1'b1;
                        end
                    end
                    ARMED: begin
                        if (bus.i_trigger) begin
                            if (start_q == '0) begin
                                state    <= INJECT;
                                en_super <= 1'b1;
                                en_basic <= mask_q;
                                ctrl_out <= ctrl_q;
                                cnt      <= dur_q - 1'b1;
                            end else begin
                                state <= DELAY;
                                cnt   <= start_q - 1'b1;
                            end
                        end
                    end
                    DELAY: begin
                        if (cnt == '0) begin
                            state    <= INJECT;
                            en_super <= 1'b1;
                            en_basic <= mask_q;
                            ctrl_out <= ctrl_q;
                            cnt      <= dur_q - 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    INJECT: begin
                        // dur of zero is a permanent fault: only an abort ends it.
                        if (dur_q != '0) begin
                            if (cnt == '0) begin
                                state    <= DONE;
                                en_super <= 1'b0;
                                en_basic <= '0;
                                ctrl_out <= '0;
                                done     <= 1'b1;
                                if (inj_cnt != {CNT_W{1'b1}}) begin
                                    inj_cnt <= inj_cnt + 1'b1;
                                end
                            end else begin
                                cnt <= cnt - 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        state     <= IDLE;
                        cfg_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                    default: begin
                        state     <= IDLE;
                        cfg_ready <= 1'b1;
                        busy      <= 1'b0;
                        en_super  <= 1'b0;
                        en_basic  <= '0;
                        ctrl_out  <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.o_cfg_ready         = cfg_ready;
    assign bus.o_en_super_sabouter = en_super;
    assign bus.o_en_basic_sabouter = en_basic;
    assign bus.o_ctrl              = ctrl_out;
    assign bus.o_busy              = busy;
    assign bus.o_done              = done;
    assign bus.o_inj_cnt           = inj_cnt;
    assign bus.dbg_state           = state;

endmodule

// File: tb/tb_fi_sabouter_ctrl.sv
// Bench for fi_sabouter_ctrl: the expected output trace is derived from the descriptor timing
// rules (window = [T0+start, T0+start+dur) in edges after the trigger) rather than from any state.
module tb_fi_sabouter_ctrl;
  localparam int W    = 4;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   exp_cnt;
  logic [W-1:0] exp_q[$];

  fi_sabouter_ctrl_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  fi_sabouter_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    bus.i_cfg_valid = 1'b0;
    bus.i_cfg_mask  = '0;
    bus.i_cfg_ctrl  = '0;
    bus.i_cfg_start = '0;
    bus.i_cfg_dur   = '0;
    bus.i_trigger   = 1'b0;
    bus.i_abort     = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_noise_cfg();
    bus.i_cfg_valid = 1'b1;
    bus.i_cfg_mask  = W'($urandom_range(0, MAXC));
    bus.i_cfg_ctrl  = 2'($urandom_range(0, 3));
    bus.i_cfg_start = CW'($urandom_range(0, MAXC));
    bus.i_cfg_dur   = CW'($urandom_range(0, MAXC));
  endtask

  // Full injection: accept, random gap, trigger at T0, then check every cycle after T0.
  // abort_k >= 0 raises i_abort for edge T0+abort_k+1.
  task automatic run_injection(input logic [W-1:0] mask, input logic [1:0] ctrl,
                               input int start, input int dur, input bit noise, input int abort_k);
    int gap, last_k, cnt0, exp_inj;
    bit aborted, in_win, exp_done, exp_ready;
    logic [W-1:0] exp_m;
    checks++;
    if (bus.o_cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_before_accept got %b exp 1", bus.o_cfg_ready);
    end
    bus.i_cfg_valid = 1'b1;
    bus.i_cfg_mask  = mask;
    bus.i_cfg_ctrl  = ctrl;
    bus.i_cfg_start = CW'(start);
    bus.i_cfg_dur   = CW'(dur);
    next_cycle();
    clear_inputs();
    gap = $urandom_range(0, 3);
    for (int g = 0; g <= gap; g++) begin
      checks++;
      if (bus.o_cfg_ready !== 1'b0 || bus.o_busy !== 1'b1 || bus.o_en_super_sabouter !== 1'b0) begin
        errors++;
        $display("FAIL armed_outputs g=%0d got ready=%b busy=%b en=%b exp ready=0 busy=1 en=0",
                 g, bus.o_cfg_ready, bus.o_busy, bus.o_en_super_sabouter);
      end
      if (g == gap) bus.i_trigger = 1'b1;
      else if (noise && $urandom_range(0, 1) == 1) drive_noise_cfg();
      next_cycle();
      clear_inputs();
    end
    last_k = (abort_k >= 0) ? abort_k + 1 : start + dur + 1;
    cnt0 = exp_cnt;
    exp_q.delete();
    for (int k = 0; k <= last_k; k++) begin
      in_win = (k >= start) && (dur == 0 || k < start + dur);
      if ((abort_k < 0 || k <= abort_k) && in_win) exp_q.push_back(mask);
      else exp_q.push_back('0);
    end
    for (int k = 0; k <= last_k; k++) begin
      aborted  = (abort_k >= 0) && (k > abort_k);
      in_win   = !aborted && (k >= start) && (dur == 0 || k < start + dur);
      exp_done = !aborted && dur != 0 && k == start + dur;
      exp_ready = aborted || (dur != 0 && k >= start + dur + 1);
      exp_inj  = (!aborted && dur != 0 && k >= start + dur) ? ((cnt0 < MAXC) ? cnt0 + 1 : MAXC) : cnt0;
      exp_m    = exp_q.pop_front();
      checks++;
      if (bus.o_en_super_sabouter !== in_win) begin
        errors++;
        $display("FAIL en_super k=%0d got %b exp %b", k, bus.o_en_super_sabouter, in_win);
      end
      checks++;
      if (bus.o_en_basic_sabouter !== exp_m) begin
        errors++;
        $display("FAIL en_basic k=%0d got %b exp %b", k, bus.o_en_basic_sabouter, exp_m);
      end
      checks++;
      if (bus.o_ctrl !== (in_win ? ctrl : 2'b00)) begin
        errors++;
        $display("FAIL ctrl k=%0d got %b exp %b", k, bus.o_ctrl, in_win ? ctrl : 2'b00);
      end
      checks++;
      if (bus.o_done !== exp_done) begin
        errors++;
        $display("FAIL done k=%0d got %b exp %b", k, bus.o_done, exp_done);
      end
      checks++;
      if (bus.o_cfg_ready !== exp_ready || bus.o_busy !== !exp_ready) begin
        errors++;
        $display("FAIL ready_busy k=%0d got ready=%b busy=%b exp ready=%b busy=%b",
                 k, bus.o_cfg_ready, bus.o_busy, exp_ready, !exp_ready);
      end
      checks++;
      if (bus.o_inj_cnt !== CW'(exp_inj)) begin
        errors++;
        $display("FAIL inj_cnt k=%0d got %0d exp %0d", k, bus.o_inj_cnt, exp_inj);
      end
      if (k < last_k) begin
        if (abort_k == k) bus.i_abort = 1'b1;
        if (noise && (abort_k >= 0 ? k <= abort_k : k <= last_k - 2)) begin
          if ($urandom_range(0, 1) == 1) drive_noise_cfg();
          if ($urandom_range(0, 1) == 1) bus.i_trigger = 1'b1;
        end
        next_cycle();
        clear_inputs();
      end
    end
    if (abort_k < 0 && dur != 0) exp_cnt = (cnt0 < MAXC) ? cnt0 + 1 : MAXC;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    exp_cnt = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.o_cfg_ready !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 ||
        bus.o_en_super_sabouter !== 1'b0 || bus.o_en_basic_sabouter !== '0 ||
        bus.o_ctrl !== 2'b00 || bus.o_inj_cnt !== '0) begin
      errors++;
      $display("FAIL reset_values got ready=%b busy=%b done=%b en=%b basic=%b ctrl=%b cnt=%0d exp 1,0,0,0,0,0,0",
               bus.o_cfg_ready, bus.o_busy, bus.o_done, bus.o_en_super_sabouter,
               bus.o_en_basic_sabouter, bus.o_ctrl, bus.o_inj_cnt);
    end
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_basic();
    run_injection(4'b0101, 2'b01, 3, 2, 1'b0, -1);
  endtask

  task automatic test_zero_start();
    run_injection(4'b1111, 2'b10, 0, 1, 1'b0, -1);
  endtask

  task automatic test_permanent_abort();
    run_injection(4'b0110, 2'b11, 2, 0, 1'b0, 57);
  endtask

  task automatic test_ignore_inputs();
    run_injection(4'b1010, 2'b10, 4, 5, 1'b1, -1);
    run_injection(4'b0011, 2'b01, 0, 3, 1'b1, -1);
  endtask

  task automatic test_abort_trigger();
    bus.i_cfg_valid = 1'b1;
    bus.i_cfg_mask  = 4'b1111;
    bus.i_cfg_ctrl  = 2'b11;
    bus.i_cfg_start = CW'(0);
    bus.i_cfg_dur   = CW'(3);
    next_cycle();
    clear_inputs();
    bus.i_trigger = 1'b1;
    bus.i_abort   = 1'b1;
    next_cycle();
    clear_inputs();
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (bus.o_en_super_sabouter !== 1'b0 || bus.o_en_basic_sabouter !== '0 || bus.o_done !== 1'b0 ||
          bus.o_busy !== 1'b0 || bus.o_cfg_ready !== 1'b1 || bus.o_inj_cnt !== CW'(exp_cnt)) begin
        errors++;
        $display("FAIL abort_trigger c=%0d got en=%b basic=%b done=%b busy=%b ready=%b cnt=%0d exp 0,0,0,0,1,%0d",
                 c, bus.o_en_super_sabouter, bus.o_en_basic_sabouter, bus.o_done, bus.o_busy,
                 bus.o_cfg_ready, bus.o_inj_cnt, exp_cnt);
      end
      if (c % 2 == 0) bus.i_trigger = 1'b1;
      next_cycle();
      clear_inputs();
    end
  endtask

  task automatic test_abort_accept();
    drive_noise_cfg();
    bus.i_abort = 1'b1;
    next_cycle();
    clear_inputs();
    checks++;
    if (bus.o_cfg_ready !== 1'b1 || bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_accept got ready=%b busy=%b exp ready=1 busy=0", bus.o_cfg_ready, bus.o_busy);
    end
    bus.i_trigger = 1'b1;
    next_cycle();
    clear_inputs();
    next_cycle();
    checks++;
    if (bus.o_en_super_sabouter !== 1'b0 || bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_accept_trigger got en=%b busy=%b exp en=0 busy=0",
               bus.o_en_super_sabouter, bus.o_busy);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      run_injection(W'($urandom_range(0, MAXC)), 2'($urandom_range(0, 3)),
                    $urandom_range(0, 6), $urandom_range(1, 6), 1'b1, -1);
    end
  endtask

  task automatic test_zero_mask();
    run_injection(4'b0000, 2'b01, 1, 2, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 17; n++) begin
      run_injection(W'($urandom_range(0, MAXC)), 2'($urandom_range(0, 3)), 1, 1, 1'b0, -1);
    end
  endtask

  task automatic test_max_counts();
    run_injection(4'b1001, 2'b11, MAXC, MAXC, 1'b0, -1);
  endtask

  task automatic test_async_reset();
    bus.i_cfg_valid = 1'b1;
    bus.i_cfg_mask  = 4'b1101;
    bus.i_cfg_ctrl  = 2'b10;
    bus.i_cfg_start = CW'(1);
    bus.i_cfg_dur   = CW'(10);
    next_cycle();
    clear_inputs();
    bus.i_trigger = 1'b1;
    next_cycle();
    clear_inputs();
    repeat (3) next_cycle();
    checks++;
    if (bus.o_en_super_sabouter !== 1'b1) begin
      errors++;
      $display("FAIL async_pre_inject got en=%b exp 1", bus.o_en_super_sabouter);
    end
    #2;
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    checks++;
    if (bus.o_en_super_sabouter !== 1'b0 || bus.o_en_basic_sabouter !== '0 || bus.o_ctrl !== 2'b00 ||
        bus.o_cfg_ready !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 || bus.o_inj_cnt !== '0) begin
      errors++;
      $display("FAIL async_reset got en=%b basic=%b ctrl=%b ready=%b busy=%b done=%b cnt=%0d exp 0,0,0,1,0,0,0",
               bus.o_en_super_sabouter, bus.o_en_basic_sabouter, bus.o_ctrl, bus.o_cfg_ready,
               bus.o_busy, bus.o_done, bus.o_inj_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    run_injection(4'b0111, 2'b01, 2, 3, 1'b0, -1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_cnt = 0;
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_basic();
    test_zero_start();
    test_permanent_abort();
    test_ignore_inputs();
    test_abort_trigger();
    test_abort_accept();
    test_zero_mask();
    test_random();
    test_back_to_back();
    test_max_counts();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
